// File: rtl/clkdiv_ctrl_pkg.sv
// Shared types and constants for the clkdiv_ctrl AON clock-divider controller.
package clkdiv_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2,
      STOP = 2'd3
   } state_t;

   localparam logic [7:0] CLKDIV_DEF_HALF = 8'h7f;
   localparam int         EDGE_CNT_W      = 16;

endpackage

// File: rtl/clkdiv_ctrl_if.sv
// Ratio-change handshake between software/PMU (master) and clkdiv_ctrl (slave).
interface clkdiv_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CNT_W-1:0] cfg_half;

   modport master (output cfg_valid, output cfg_half, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_half, output cfg_ready);
endinterface

// File: rtl/clkdiv_ctrl_core.sv
// Half-period counter and clk_out toggle; holds the half-period currently in force.
module clkdiv_core
   import clkdiv_ctrl_pkg::*;
#(
   parameter int               CNT_W    = 8,
   parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(CLKDIV_DEF_HALF)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             load,
   input  logic [CNT_W-1:0] load_half,
   output logic [CNT_W-1:0] cur_half,
   output logic             clk_out,
   output logic             fall_pt,
   output logic             rise_pt
);

   logic [CNT_W-1:0] cnt;
   logic             at_end;

   assign at_end  = (cnt == cur_half);
   assign fall_pt = run & at_end & clk_out;
   assign rise_pt = run & at_end & ~clk_out;

   // run is only dropped while clk_out is already low, so parking never cuts a pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         clk_out  <= 1'b0;
         cur_half <= DEF_HALF;
      end else begin
         if (!run) begin
            cnt     <= '0;
            clk_out <= 1'b0;
         end else if (at_end) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
         if (load) cur_half <= load_half;
      end
   end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Glitch-free programmable clock-divider controller (run/stop + ratio handshake).
// Optional feature macro: CLKDIV_CTRL_EDGE_CNT_EN adds the 16-bit edge_cnt tick counter.
module clkdiv_ctrl
   import clkdiv_ctrl_pkg::*;
#(
   parameter int               CNT_W    = 8,
   parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(CLKDIV_DEF_HALF)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   clkdiv_ctrl_if.slave          cfg,
   output logic                  clk_out,
   output logic                  tick,
   output logic                  busy,
`ifdef CLKDIV_CTRL_EDGE_CNT_EN
   output logic [EDGE_CNT_W-1:0] edge_cnt,
`endif
   output logic [CNT_W-1:0]      cur_half
);

   state_t           state, state_n;
   logic [CNT_W-1:0] pend_half;
   logic             pend_v;
   logic             run, load;
   logic             fall_pt, rise_pt;

   assign pend_v = ~cfg.cfg_ready;

   clkdiv_core #(.CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) u_core (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .load      (load),
      .load_half (pend_half),
      .cur_half  (cur_half),
      .clk_out   (clk_out),
      .fall_pt   (fall_pt),
      .rise_pt   (rise_pt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // STOP waits for clk_out low, so a high phase always completes
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (en) state_n = RUN;
         RUN:  if (!en) state_n = STOP;
               else if (pend_v && !fall_pt) state_n = PEND;
         PEND: if (!en) state_n = STOP;
               else if (fall_pt || !pend_v) state_n = RUN;
         STOP: if (!clk_out) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // A pending ratio only lands on a falling toggle or while parked low
   always_comb begin
      run  = 1'b0;
      load = 1'b0;
      unique case (state)
         IDLE: load = pend_v;
         RUN, PEND: begin
            run  = en | clk_out;
            load = pend_v & fall_pt;
         end
         STOP: begin
            run  = clk_out;
            load = pend_v & ~clk_out;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg.cfg_ready <= 1'b1;
         pend_half     <= '0;
         tick          <= 1'b0;
         busy          <= 1'b0;
      end else begin
         if (load) begin
            cfg.cfg_ready <= 1'b1;
         end else if (cfg.cfg_valid && cfg.cfg_ready) begin
            cfg.cfg_ready <= 1'b0;
            pend_half     <= cfg.cfg_half;
         end
         tick <= rise_pt;
         busy <= (state_n != IDLE);
      end
   end

`ifdef CLKDIV_CTRL_EDGE_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        edge_cnt <= '0;
      else if (rise_pt) edge_cnt <= edge_cnt + EDGE_CNT_W'(1);
   end
`endif

endmodule
